pad_ctrl: RTL and testbench

Core-side controller for the bidirectional pad cell: drives the pad's `DIN`/`OEN`/`PULL` controls and receives its `DOUT`. It sequences direction changes with a guaranteed turnaround, synchronizes and glitch-filters the returning pad input, and reports filtered edges. It sits between GPIO/peripheral logic and one `pad` instance. Pad conventions:
- `OEN=1` is input mode and releases the pad; `OEN=0` drives `DIN` onto the pad.
- `PULL`: `2'b10` pull-down, `2'b11` pull-up, `2'b00` no pull.

---
 rtl/pad_ctrl_if.sv | 43 ++++
 rtl/pad_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_pad_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pad_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pad_ctrl_if
// Purpose  : Bundle of core-side and pad-side signals around one pad_ctrl.
//            master = GPIO/peripheral logic plus pad model,
//            slave  = pad_ctrl.
// Signals  : dir_req  1 = request output, 0 = request input
//            out_val  value to drive in output mode
//            pull_cfg pull setting used in input mode (10 down, 11 up, 00 off)
//            filt_len extra stable cycles before an input change is accepted
//            DIN/OEN/PULL  registered pad controls (OEN=1 releases the pad)
//            DOUT     pad input, asynchronous to clk
//            in_val/rise/fall  filtered level and its edge pulses
//            busy     direction turnaround in progress
// Revision : 1.0  initial release
// ============================================================================
interface pad_ctrl_if #(
  parameter int FILT_W = 4
);
  logic              dir_req;
  logic              out_val;
  logic [1:0]        pull_cfg;
  logic [FILT_W-1:0] filt_len;
  logic              DIN;
  logic              OEN;
  logic [1:0]        PULL;
  logic              DOUT;
  logic              in_val;
  logic              rise;
  logic              fall;
  logic              busy;

  modport master (
    output dir_req, out_val, pull_cfg, filt_len, DOUT,
    input  DIN, OEN, PULL, in_val, rise, fall, busy
  );

  modport slave (
    input  dir_req, out_val, pull_cfg, filt_len, DOUT,
    output DIN, OEN, PULL, in_val, rise, fall, busy
  );
endinterface
`default_nettype wire

// File: rtl/pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pad_ctrl
// Purpose  : Core-side controller for a bidirectional pad cell. Sequences
//            direction changes through a fixed turnaround, synchronizes and
//            glitch-filters the returning pad level and reports its edges.
// Ports    : clk  system clock, rising edge
//            rst  asynchronous active-high reset; releases the pad at once
//            bus  pad_ctrl_if.slave (direction request, drive value, pull
//                 config, filter length, pad controls, filtered input)
// Params   : FILT_W   width of filt_len and the filter counter
//            TURN_CYC turnaround length in clocks (1..15)
// Config   : PAD_CTRL_EDGE_EN defined   -> rise/fall pulses generated
//            PAD_CTRL_EDGE_EN undefined -> rise/fall tied low
// Revision : 1.0  initial release
// ============================================================================
module pad_ctrl #(
  parameter int FILT_W   = 4,
  parameter int TURN_CYC = 2
) (
  input  wire          clk,
  input  wire          rst,
  pad_ctrl_if.slave    bus
);

  localparam logic [3:0] c_TURN_LOAD = 4'(TURN_CYC - 1);

  typedef enum logic [1:0] {
    ST_IN     = 2'd0,
    ST_TO_OUT = 2'd1,
    ST_OUT    = 2'd2,
    ST_TO_IN  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_turn_cnt;
  logic [3:0]  w_turn_nxt;

  logic        r_oen;
  logic        r_din;
  logic [1:0]  r_pull;
  logic        r_busy;
  logic        w_oen_nxt;
  logic        w_din_nxt;
  logic [1:0]  w_pull_nxt;
  logic        w_busy_nxt;

  logic              r_sync1;
  logic              r_sync2;
  logic [FILT_W-1:0] r_filt_cnt;
  logic [FILT_W-1:0] w_filt_nxt;
  logic              r_in_val;
  logic              w_in_val_nxt;

  // --------------------------------------------------------------------------
  // Direction FSM: state and turnaround counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IN;
      r_turn_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_turn_cnt <= w_turn_nxt;
    end
  end

  // A turnaround always runs to completion; dir_req is only looked at in the
  // two settled states.
  always_comb begin
    w_state_nxt = r_state;
    w_turn_nxt  = r_turn_cnt;
    case (r_state)
      ST_IN: begin
        if (bus.dir_req) begin
          w_state_nxt = ST_TO_OUT;
          w_turn_nxt  = c_TURN_LOAD;
        end
      end
      ST_TO_OUT: begin
        if (r_turn_cnt == 4'd0) w_state_nxt = ST_OUT;
        else                    w_turn_nxt  = r_turn_cnt - 4'd1;
      end
      ST_OUT: begin
        if (!bus.dir_req) begin
          w_state_nxt = ST_TO_IN;
          w_turn_nxt  = c_TURN_LOAD;
        end
      end
      ST_TO_IN: begin
        if (r_turn_cnt == 4'd0) w_state_nxt = ST_IN;
        else                    w_turn_nxt  = r_turn_cnt - 4'd1;
      end
      default: begin
        w_state_nxt = ST_IN;
        w_turn_nxt  = 4'd0;
      end
    endcase
  end

  // Pad controls are decoded from the next state so they change on the same
  // edge as the state. Only ST_OUT drives the pad, and it never carries a
  // pull, so a pull can never fight the driver.
  always_comb begin
    w_oen_nxt  = 1'b1;
    w_din_nxt  = 1'b0;
    w_pull_nxt = 2'b00;
    w_busy_nxt = 1'b0;
    case (w_state_nxt)
      ST_IN: begin
        w_pull_nxt = bus.pull_cfg;
      end
      ST_TO_OUT: begin
        w_din_nxt  = bus.out_val;
        w_busy_nxt = 1'b1;
      end
      ST_OUT: begin
        w_oen_nxt  = 1'b0;
        w_din_nxt  = bus.out_val;
      end
      ST_TO_IN: begin
        w_pull_nxt = bus.pull_cfg;
        w_busy_nxt = 1'b1;
      end
      default: begin
        w_oen_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_oen  <= 1'b1;
      r_din  <= 1'b0;
      r_pull <= 2'b00;
      r_busy <= 1'b0;
    end else begin
      r_oen  <= w_oen_nxt;
      r_din  <= w_din_nxt;
      r_pull <= w_pull_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Input path: 2-flop synchronizer, then a stability filter that only runs
  // while the pad is settled in input mode. During any other state the pad
  // level reflects our own drive or a turnaround, so in_val is frozen.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.DOUT;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_filt_nxt   = '0;
    w_in_val_nxt = r_in_val;
    if (r_state == ST_IN) begin
      if (r_sync2 == r_in_val) begin
        w_filt_nxt = '0;
      end else if (r_filt_cnt == bus.filt_len) begin
        // Input differed for filt_len+1 consecutive samples: accept it.
        w_in_val_nxt = r_sync2;
        w_filt_nxt   = '0;
      end else begin
        w_filt_nxt = r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt_cnt <= '0;
      r_in_val   <= 1'b0;
    end else begin
      r_filt_cnt <= w_filt_nxt;
      r_in_val   <= w_in_val_nxt;
    end
  end

`ifdef PAD_CTRL_EDGE_EN
  logic r_rise;
  logic r_fall;

  // Pulses are registered alongside in_val so they line up with its change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= ~r_in_val &  w_in_val_nxt;
      r_fall <=  r_in_val & ~w_in_val_nxt;
    end
  end

  assign bus.rise = r_rise;
  assign bus.fall = r_fall;
`else
  assign bus.rise = 1'b0;
  assign bus.fall = 1'b0;
`endif

  assign bus.OEN    = r_oen;
  assign bus.DIN    = r_din;
  assign bus.PULL   = r_pull;
  assign bus.busy   = r_busy;
  assign bus.in_val = r_in_val;

endmodule
`default_nettype wire

// File: tb/tb_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pad_ctrl
// Purpose  : Self-checking bench for pad_ctrl (FILT_W=4, TURN_CYC=2).
//            Cycle table for pull tracking, filtering, output entry/exit,
//            then hand sequences for filt_len=0 latency, a one-cycle
//            dir_req pulse and asynchronous reset while driving.
//            Expected edge pulses follow PAD_CTRL_EDGE_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_pad_ctrl;

`ifdef PAD_CTRL_EDGE_EN
  localparam bit EDGE_ON = 1'b1;
`else
  localparam bit EDGE_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  pad_ctrl_if #(.FILT_W(4)) bus ();

  pad_ctrl #(.FILT_W(4), .TURN_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dir;
    logic       ov;
    logic [1:0] pull;
    logic       dout;
    logic       oen;
    logic       din;
    logic [1:0] epull;
    logic       busy;
    logic       inval;
    logic       rise;
    logic       fall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic dir, input logic ov,
                              input logic [1:0] pull, input logic dout,
                              input logic oen, input logic din,
                              input logic [1:0] epull, input logic busy,
                              input logic inval, input logic rise,
                              input logic fall);
    vec_t v;
    v.dir = dir; v.ov = ov; v.pull = pull; v.dout = dout;
    v.oen = oen; v.din = din; v.epull = epull; v.busy = busy;
    v.inval = inval; v.rise = rise & EDGE_ON; v.fall = fall & EDGE_ON;
    return v;
  endfunction

  // {0, OEN, DIN, PULL[1:0], busy, in_val, rise, fall}
  function automatic logic [8:0] outs();
    return {1'b0, bus.OEN, bus.DIN, bus.PULL, bus.busy, bus.in_val,
            bus.rise, bus.fall};
  endfunction

  function automatic logic [8:0] pack(input logic oen, input logic din,
                                      input logic [1:0] pull, input logic busy,
                                      input logic inval, input logic rise,
                                      input logic fall);
    return {1'b0, oen, din, pull, busy, inval, rise & EDGE_ON, fall & EDGE_ON};
  endfunction

  task automatic check(input string name, input logic [8:0] act,
                       input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (oen,din,pull,busy,inval,rise,fall)",
               name, act[7:0], exp[7:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.dir_req  = 1'b0;
    bus.out_val  = 1'b0;
    bus.pull_cfg = 2'b11;
    bus.filt_len = 4'd3;
    bus.DOUT     = 1'b0;

    //        dir ov  pull  dout  oen din epull busy inv rise fall
    vecs.push_back(mk(0,0,2'b11,0, 1,0,2'b11,0,0,0,0));   // 0 pull after reset
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(0,0,2'b11,1, 1,0,2'b11,0,0,0,0)); // 1..5 filtering
    vecs.push_back(mk(0,0,2'b11,1, 1,0,2'b11,0,1,1,0));   // 6 accept + rise
    vecs.push_back(mk(0,0,2'b11,1, 1,0,2'b11,0,1,0,0));   // 7
    for (int i = 8; i <= 10; i++)
      vecs.push_back(mk(0,0,2'b11,0, 1,0,2'b11,0,1,0,0)); // 8..10 glitch
    for (int i = 11; i <= 13; i++)
      vecs.push_back(mk(0,0,2'b10,1, 1,0,2'b10,0,1,0,0)); // 11..13 pull live
    vecs.push_back(mk(1,1,2'b10,1, 1,1,2'b00,1,1,0,0));   // 14 TO_OUT
    vecs.push_back(mk(1,1,2'b10,0, 1,1,2'b00,1,1,0,0));   // 15 TO_OUT
    vecs.push_back(mk(1,1,2'b10,0, 0,1,2'b00,0,1,0,0));   // 16 OUT
    vecs.push_back(mk(1,0,2'b10,0, 0,0,2'b00,0,1,0,0));   // 17 DIN follows
    vecs.push_back(mk(1,1,2'b10,0, 0,1,2'b00,0,1,0,0));   // 18 DIN follows
    vecs.push_back(mk(0,1,2'b10,0, 1,0,2'b10,1,1,0,0));   // 19 TO_IN
    vecs.push_back(mk(0,1,2'b10,0, 1,0,2'b10,1,1,0,0));   // 20 TO_IN
    for (int i = 21; i <= 24; i++)
      vecs.push_back(mk(0,0,2'b10,0, 1,0,2'b10,0,1,0,0)); // 21..24 IN, filter
    vecs.push_back(mk(0,0,2'b10,0, 1,0,2'b10,0,0,0,1));   // 25 fall
    vecs.push_back(mk(0,0,2'b10,0, 1,0,2'b10,0,0,0,0));   // 26

    #2;
    check("reset_state", outs(), pack(1,0,2'b00,0,0,0,0));
    #19;
    rst = 1'b0;

    foreach (vecs[i]) begin
      bus.dir_req  = vecs[i].dir;
      bus.out_val  = vecs[i].ov;
      bus.pull_cfg = vecs[i].pull;
      bus.DOUT     = vecs[i].dout;
      tick();
      check($sformatf("vec[%0d]", i), outs(),
            pack(vecs[i].oen, vecs[i].din, vecs[i].epull, vecs[i].busy,
                 vecs[i].inval, vecs[i].rise, vecs[i].fall));
    end

    // filt_len=0: DOUT change reaches in_val on the third edge
    bus.filt_len = 4'd0;
    bus.DOUT     = 1'b1;
    tick();
    tick();
    check("filt0_edge2", outs(), pack(1,0,2'b10,0,0,0,0));
    tick();
    check("filt0_edge3", outs(), pack(1,0,2'b10,0,1,1,0));

    // one-cycle dir_req pulse: full TO_OUT, one OUT cycle, then TO_IN
    bus.dir_req = 1'b1;
    bus.out_val = 1'b0;
    tick();
    check("pulse_e1", outs(), pack(1,0,2'b00,1,1,0,0));
    bus.dir_req = 1'b0;
    tick();
    check("pulse_e2", outs(), pack(1,0,2'b00,1,1,0,0));
    tick();
    check("pulse_e3_out", outs(), pack(0,0,2'b00,0,1,0,0));
    tick();
    check("pulse_e4_toin", outs(), pack(1,0,2'b10,1,1,0,0));
    tick();
    check("pulse_e5_toin", outs(), pack(1,0,2'b10,1,1,0,0));
    tick();
    check("pulse_e6_in", outs(), pack(1,0,2'b10,0,1,0,0));

    // asynchronous reset while driving
    bus.dir_req = 1'b1;
    bus.out_val = 1'b1;
    tick();
    tick();
    tick();
    check("pre_reset_out", outs(), pack(0,1,2'b00,0,1,0,0));
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", outs(), pack(1,0,2'b00,0,0,0,0));
    #10;
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
